// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory-port sequencer.
package mem_ctrl_pkg;

    // Upper bound on the number of cores any sequencer instance can serve.
    localparam int MAX_CORES = 16;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLOT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Operation latched at acceptance.
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Effective core count: 0 means one core, anything above the instance size saturates.
    function automatic int unsigned clamp_noc(input int unsigned noc, input int unsigned num_cores);
        if (noc == 0) begin
            return 1;
        end else if (noc > num_cores) begin
            return num_cores;
        end else begin
            return noc;
        end
    endfunction

    // Capture-strobe mask with the low num_cores bits set (shared-read broadcast).
    function automatic logic [MAX_CORES-1:0] strobe_all_mask(input int unsigned num_cores);
        logic [MAX_CORES-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_CORES; i++) begin
            if (i < num_cores) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/mem_access_sequencer_slot_timer.sv
// Loadable down-counter that marks the last cycle of a core slot.
module slot_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             slot_end
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on slot start, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The slot's final cycle is the one where the count has reached zero.
    assign slot_end = (cnt_q == '0);

endmodule

// File: rtl/mem_access_sequencer.sv
// Time-multiplexes one shared memory port across the compute cores: drives the
// address / write-data mux selects and the per-core read-data capture strobes.
module mem_access_sequencer
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int SEL_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    parameter int NOC_W       = 3,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           read,
    input  logic [1:0]           write,
    input  logic [NOC_W-1:0]     noc,
    output logic [SEL_W-1:0]     mux_address_sig,
    output logic [SEL_W-1:0]     mux_data_in_sig,
    output logic [NUM_CORES-1:0] mux_data_out_sig,
    output logic                 busy,
    output logic                 done
);

    localparam int TIMER_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [MAX_CORES-1:0] STROBE_ALL = strobe_all_mask(NUM_CORES);

    // Control state.
    state_e               state_q, state_d;
    logic [SEL_W-1:0]     core_q, core_d;
    logic [SEL_W-1:0]     last_q, last_d;
    logic                 op_q, op_d;
    logic                 mode_q, mode_d;

    // Registered outputs.
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_CORES-1:0] strobe_q, strobe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Slot timer interface.
    logic                 timer_load;
    logic                 slot_end;
    logic                 slot_done;

    slot_timer #(
        .CNT_W (TIMER_W)
    ) u_slot_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (TIMER_W'(WAIT_CYCLES)),
        .slot_end (slot_end)
    );

    assign slot_done = (state_q == SLOT) && slot_end;

    // State and output registers; reset aborts any operation without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            core_q   <= '0;
            last_q   <= '0;
            op_q     <= OP_RD;
            mode_q   <= 1'b0;
            sel_q    <= '0;
            strobe_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            core_q   <= core_d;
            last_q   <= last_d;
            op_q     <= op_d;
            mode_q   <= mode_d;
            sel_q    <= sel_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state: accept in IDLE (write beats read), walk the slots, one drain cycle.
    always_comb begin
        state_d    = state_q;
        core_d     = core_q;
        last_d     = last_q;
        op_d       = op_q;
        mode_d     = mode_q;
        timer_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (write[0] || read[0]) begin
                    op_d       = write[0] ? OP_WR : OP_RD;
                    mode_d     = write[0] ? write[1] : read[1];
                    // Shared-address operations touch memory once, so they get a single slot.
                    last_d     = mode_d ? SEL_W'(clamp_noc(32'(noc), NUM_CORES) - 1) : '0;
                    core_d     = '0;
                    timer_load = 1'b1;
                    state_d    = SLOT;
                end
            end
            SLOT: begin
                if (slot_end) begin
                    if (core_q == last_q) begin
                        state_d = DRAIN;
                    end else begin
                        core_d     = SEL_W'(core_q + 1'b1);
                        timer_load = 1'b1;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from where the FSM is heading.
    always_comb begin
        sel_d    = (state_d == SLOT) ? core_d : '0;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DRAIN);
        strobe_d = '0;
        // Read data for core k is valid the cycle after its slot ends.
        if (slot_done && (op_q == OP_RD)) begin
            if (mode_q) begin
                strobe_d = NUM_CORES'(1) << core_q;
            end else begin
                strobe_d = STROBE_ALL[NUM_CORES-1:0];
            end
        end
    end

    assign mux_address_sig  = sel_q;
    assign mux_data_in_sig  = sel_q;
    assign mux_data_out_sig = strobe_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Parametrised memory-port sequencer for the matrix multiplier, sitting between the core array and the single shared data memory.
- Time-multiplexes one memory port across up to NUM_CORES compute cores.
- Drives the address/data-in mux selects and per-core read-data capture strobes.
- Compared with the 4-core fixed sequencer it adds parametrised core count, programmable per-slot wait states for slower memories, noc clamping, a busy/done handshake and synchronous reset.

Parameters:
- NUM_CORES, 4, number of cores served; 1..16.
- SEL_W, $clog2(NUM_CORES) (min 1), width of the mux select outputs.
- NOC_W, 3, width of the noc input; must hold NUM_CORES.
- WAIT_CYCLES, 0, extra cycles each core slot is held (memory access time minus 1); 0..15.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- read, input, 2, [0] = read request, [1] = per-core distinct addresses (0 = shared address, broadcast).
- write, input, 2, [0] = write request, [1] = per-core distinct addresses/data.
- noc, input, NOC_W, number of active cores for this operation.
- mux_address_sig, output, SEL_W, address mux select (core index).
- mux_data_in_sig, output, SEL_W, write-data mux select; always equal to mux_address_sig.
- mux_data_out_sig, output, NUM_CORES, one-hot/all-ones read-data capture strobes.
- busy, output, 1, operation in progress; requests ignored while high.
- done, output, 1, one-cycle pulse on the final (drain) cycle.

Behaviour:
- All outputs are registered. Reset values: mux_address_sig = 0, mux_data_in_sig = 0, mux_data_out_sig = 0, busy = 0, done = 0, state = IDLE, counters = 0.
- rst has priority on every edge and is legal mid-operation: abort to IDLE, outputs zero next cycle, no done pulse.
- States:
  - IDLE: outputs zero. Sampled only in IDLE, write[0] has priority over read[0]. On acceptance, latch op (WR/RD), mode bit and n_eff = clamp(noc). clamp: 0 -> 1, >NUM_CORES -> NUM_CORES.
  - Shared mode (bit[1] = 0): n_eff forced to 1.
  - SLOT: core index k runs 0..n_eff-1. Each slot lasts WAIT_CYCLES+1 cycles. mux_address_sig = mux_data_in_sig = k. busy = 1.
  - DRAIN: exactly 1 cycle after the last slot. Selects = 0, busy = 1, done = 1. Next state IDLE.
- Read strobes, one-cycle memory read latency:
  - Strobe for core k is asserted only in the first cycle after slot k ends, i.e. the first cycle of slot k+1 or of DRAIN.
  - Distinct read: bit k, one-hot. Shared read: all NUM_CORES bits set in DRAIN.
  - Writes never assert strobes.
- Timing: request sampled at edge T gives sel = 0 from T+1. busy spans n_eff*(WAIT_CYCLES+1)+1 cycles. IDLE is re-entered at the following edge, and a new request may be sampled at that edge.
- Requests held high during busy are neither queued nor counted. If still asserted in IDLE they start a new operation (level-sensitive).
- noc, read and write changes mid-operation have no effect (latched at acceptance).
- read[1]/write[1] without bit[0] set is ignored.

Decomposition:
- Package mem_ctrl_pkg holds:
  - state encoding IDLE/SLOT/DRAIN;
  - op constants OP_RD/OP_WR;
  - clamp_noc function;
  - STROBE_ALL constant helper.
- One sub-module, slot_timer: loadable down-counter of width $clog2(WAIT_CYCLES+1) (min 1) with a slot_end pulse. It is instantiated once; the core index counter stays in the top.

Test Plan:
1. NUM_CORES=4, WAIT=0, read=2'b11, noc=3 at T -> T+1..T+3 sel = 0,1,2; strobes 0000,0001,0010; T+4 sel = 0, strobe 0100, done = 1; busy high 4 cycles.
2. read=2'b01, noc=4 -> T+1 sel = 0, strobe 0000; T+2 strobe 1111, done = 1; busy 2 cycles.
3. write=2'b11 and read=2'b11 together, noc=2, WAIT=1 -> write wins; sel = 0,0,1,1,0; strobes always 0000; done at T+5.
4. noc=0 -> treated as 1; noc=7 with NUM_CORES=4 -> 4 slots; strobes 0001..1000 in sequence.
5. rst asserted during slot 2 of a 4-core read -> next cycle all outputs 0, busy = 0, no done; a fresh request after that runs normally from core 0.
6. Request held high across busy -> back-to-back operations with exactly one IDLE cycle between them; noc changed mid-operation is ignored.
